// File: rtl/envelope_sequencer_pkg.sv
// Shared audio definitions for the envelope sequencer: sample width, default
// watchdog length and the ADSR phase encoding.
package envelope_sequencer_pkg;

    localparam int unsigned AUDIO_W                = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1048576;

    // Encoding is visible on the state output, so the values are fixed.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } env_state_e;

    // Config captured on a trigger and used by later phases. Peak level and
    // attack speed go straight into target/speed, which then act as their shadow.
    typedef struct packed {
        logic [AUDIO_W-1:0] sustain_level;
        logic [AUDIO_W-1:0] decay_speed;
        logic [AUDIO_W-1:0] release_speed;
    } env_shadow_t;

    // Phases in which the lerper is ramping and the watchdog runs.
    function automatic logic is_ramp(env_state_e s);
        return (s == StAttack) || (s == StDecay) || (s == StRelease);
    endfunction

endpackage

// File: rtl/envelope_sequencer_if.sv
// Bundle between the note/gate logic plus lerper (master) and the envelope
// sequencer (slave).
interface envelope_sequencer_if;
    import envelope_sequencer_pkg::*;

    logic               gate_on;
    logic               gate_off;
    logic [AUDIO_W-1:0] peak_level;
    logic [AUDIO_W-1:0] sustain_level;
    logic [AUDIO_W-1:0] attack_speed;
    logic [AUDIO_W-1:0] decay_speed;
    logic [AUDIO_W-1:0] release_speed;
    logic [AUDIO_W-1:0] lerp_value;
    logic [AUDIO_W-1:0] target;
    logic [AUDIO_W-1:0] speed;
    logic [2:0]         state;
    logic               busy;
    logic               timeout_flag;

    modport master (
        output gate_on, gate_off, peak_level, sustain_level,
               attack_speed, decay_speed, release_speed, lerp_value,
        input  target, speed, state, busy, timeout_flag
    );

    modport slave (
        input  gate_on, gate_off, peak_level, sustain_level,
               attack_speed, decay_speed, release_speed, lerp_value,
        output target, speed, state, busy, timeout_flag
    );

endinterface

// File: rtl/envelope_sequencer_phase_timer.sv
// Watchdog for a single ramp phase: counts enabled cycles since the last clear
// and flags when TIMEOUT_CYCLES-1 is reached.
module phase_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    assign expired = (count_q == LAST);

    // Cycle counter: clear wins, otherwise count up and saturate at LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/envelope_sequencer.sv
// Per-voice ADSR sequencer: steers a lerper's target and speed through
// attack, decay, sustain and release, using lerper feedback plus a watchdog.
module envelope_sequencer
    import envelope_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    envelope_sequencer_if.slave bus
);

    env_state_e         state_q;
    logic [AUDIO_W-1:0] target_q;
    logic [AUDIO_W-1:0] speed_q;
    logic               timeout_q;
    env_shadow_t        shadow_q;

    logic reached;
    logic ramp;
    logic go_attack;
    logic go_release;
    logic advance;
    logic expired;
    logic timer_clear;

    // Event decode in priority order: trigger, release, phase completion.
    always_comb begin
        reached     = (bus.lerp_value == target_q);
        ramp        = is_ramp(state_q);
        go_attack   = bus.gate_on;
        go_release  = !bus.gate_on && bus.gate_off &&
                      ((state_q == StAttack) || (state_q == StDecay) ||
                       (state_q == StSustain));
        advance     = !go_attack && !go_release && ramp && (reached || expired);
        // Retrigger restarts the watchdog even though the state is unchanged.
        timer_clear = go_attack || go_release || advance;
    end

    phase_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_phase_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (ramp),
        .expired(expired)
    );

    // Phase FSM with registered target, speed, sticky timeout and config shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            target_q  <= '0;
            speed_q   <= '0;
            timeout_q <= 1'b0;
            shadow_q  <= '0;
        end else if (go_attack) begin
            // Lerper output is left alone so the ramp continues from where it is.
            state_q                <= StAttack;
            target_q               <= bus.peak_level;
            speed_q                <= bus.attack_speed;
            timeout_q              <= 1'b0;
            shadow_q.sustain_level <= bus.sustain_level;
            shadow_q.decay_speed   <= bus.decay_speed;
            shadow_q.release_speed <= bus.release_speed;
        end else if (go_release) begin
            state_q  <= StRelease;
            target_q <= '0;
            speed_q  <= shadow_q.release_speed;
        end else if (advance) begin
            if (expired) begin
                timeout_q <= 1'b1;
            end
            case (state_q)
                StAttack: begin
                    state_q  <= StDecay;
                    target_q <= shadow_q.sustain_level;
                    speed_q  <= shadow_q.decay_speed;
                end
                StDecay: begin
                    state_q <= StSustain;
                end
                StRelease: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign bus.state        = state_q;
    assign bus.target       = target_q;
    assign bus.speed        = speed_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.timeout_flag = timeout_q;

endmodule

// File: tb/tb_envelope_sequencer.sv
// Bench for envelope_sequencer: vector table, hand-written ADSR/retrigger/
// timeout/shadow/reset sequences, and a randomized run against a reference model.
module tb_envelope_sequencer;
    import envelope_sequencer_pkg::*;

    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_t;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    envelope_sequencer_if bus_a ();
    envelope_sequencer_if bus_t ();

    envelope_sequencer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES_DEFAULT)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a)
    );
    envelope_sequencer #(.TIMEOUT_CYCLES(TO)) dut_t (
        .clk(clk), .rst(rst_t), .bus(bus_t)
    );

    // Behavioural lerper: move by |speed| per cycle toward target, clamped.
    function automatic logic [15:0] lerp_step(input logic [15:0] cur, input logic [15:0] tgt,
                                              input logic [15:0] spd);
        int mag;
        int nxt;
        mag = $signed(spd);
        if (mag < 0) mag = -mag;
        if (cur < tgt) begin
            nxt = int'(cur) + mag;
            if (nxt > int'(tgt)) nxt = int'(tgt);
        end else begin
            nxt = int'(cur) - mag;
            if (nxt < int'(tgt)) nxt = int'(tgt);
        end
        return 16'(nxt);
    endfunction

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) bus_a.lerp_value <= '0;
        else       bus_a.lerp_value <= lerp_step(bus_a.lerp_value, bus_a.target, bus_a.speed);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic check_out(input string name, input logic [2:0] st, input logic [15:0] tgt,
                             input logic [15:0] spd, input logic busy, input logic flag,
                             input logic [2:0] est, input logic [15:0] etgt,
                             input logic [15:0] espd, input logic eflag);
        logic ebusy;
        ebusy = (est != 3'd0);
        total_cnt++;
        if ({st, tgt, spd, busy, flag} === {est, etgt, espd, ebusy, eflag}) pass_cnt++;
        else $display("FAIL %s: got st=%0d tgt=%0d spd=%0d busy=%0b to=%0b required st=%0d tgt=%0d spd=%0d busy=%0b to=%0b",
                      name, st, tgt, spd, busy, flag, est, etgt, espd, ebusy, eflag);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        gon;
        logic        goff;
        logic [15:0] peak;
        logic [15:0] sus;
        logic [15:0] lerp;
        logic [2:0]  st;
        logic [15:0] tgt;
        logic [15:0] spd;
    } vec_t;

    function automatic vec_t mk(input logic gon, input logic goff, input int peak, input int sus,
                                input int lerp, input int st, input int tgt, input int spd);
        vec_t v;
        v.gon = gon; v.goff = goff; v.peak = 16'(peak); v.sus = 16'(sus);
        v.lerp = 16'(lerp); v.st = 3'(st); v.tgt = 16'(tgt); v.spd = 16'(spd);
        return v;
    endfunction

    vec_t vecs[14];

    // Reference model state for the randomized run.
    int          m_state;
    int          m_age;
    logic [15:0] m_tgt, m_spd, m_sus, m_ds, m_rs;
    logic        m_flag;

    task automatic model_step(input logic gon, input logic goff, input logic [15:0] peak,
                              input logic [15:0] sus, input logic [15:0] as,
                              input logic [15:0] ds, input logic [15:0] rs,
                              input logic [15:0] lerp);
        bit ramping, reached, expired, changed;
        ramping = (m_state == 1) || (m_state == 2) || (m_state == 4);
        reached = (lerp == m_tgt);
        expired = ramping && (m_age == int'(TO) - 1);
        changed = 1'b1;
        if (gon) begin
            m_state = 1; m_tgt = peak; m_spd = as; m_flag = 1'b0;
            m_sus = sus; m_ds = ds; m_rs = rs;
        end else if (goff && (m_state >= 1) && (m_state <= 3)) begin
            m_state = 4; m_tgt = 16'd0; m_spd = m_rs;
        end else if (ramping && (reached || expired)) begin
            if (expired) m_flag = 1'b1;
            if (m_state == 1) begin
                m_state = 2; m_tgt = m_sus; m_spd = m_ds;
            end else if (m_state == 2) begin
                m_state = 3;
            end else begin
                m_state = 0;
            end
        end else begin
            changed = 1'b0;
        end
        if (changed) m_age = 0;
        else if ((m_state == 1) || (m_state == 2) || (m_state == 4)) m_age++;
        else m_age = 0;
    endtask

    task automatic drive_t(input logic gon, input logic goff, input logic [15:0] peak,
                           input logic [15:0] sus, input logic [15:0] as,
                           input logic [15:0] ds, input logic [15:0] rs,
                           input logic [15:0] lerp);
        bus_t.gate_on = gon; bus_t.gate_off = goff; bus_t.peak_level = peak;
        bus_t.sustain_level = sus; bus_t.attack_speed = as; bus_t.decay_speed = ds;
        bus_t.release_speed = rs; bus_t.lerp_value = lerp;
    endtask

    initial begin
        logic [2:0]  seq_st[$];
        logic [15:0] seq_tgt[$];
        logic [2:0]  prev;
        int          n;
        logic        gon, goff;
        logic [15:0] peak, sus, as, ds, rs, lerp;

        rst_a = 1'b1;
        rst_t = 1'b1;
        bus_a.gate_on = 1'b0; bus_a.gate_off = 1'b0;
        bus_a.peak_level = '0; bus_a.sustain_level = '0;
        bus_a.attack_speed = '0; bus_a.decay_speed = '0; bus_a.release_speed = '0;
        drive_t(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        check_out("reset_a", bus_a.state, bus_a.target, bus_a.speed, bus_a.busy,
                  bus_a.timeout_flag, 3'd0, 16'd0, 16'd0, 1'b0);
        check_out("reset_t", bus_t.state, bus_t.target, bus_t.speed, bus_t.busy,
                  bus_t.timeout_flag, 3'd0, 16'd0, 16'd0, 1'b0);
        rst_a = 1'b0;
        rst_t = 1'b0;

        // ---------------- vector table on the short-timeout instance ----------------
        vecs[0]  = mk(0, 1, 300, 100,   0, 0,   0,  0);  // gate_off in IDLE ignored
        vecs[1]  = mk(1, 0, 300, 100,   0, 1, 300, 11);
        vecs[2]  = mk(0, 0, 300, 100, 300, 2, 100, 22);
        vecs[3]  = mk(0, 0, 300, 100, 100, 3, 100, 22);
        vecs[4]  = mk(1, 1, 300, 100, 100, 1, 300, 11);  // gate_on beats gate_off
        vecs[5]  = mk(0, 1, 300, 100,   0, 4,   0, 33);
        vecs[6]  = mk(0, 1, 300, 100,  50, 4,   0, 33);  // gate_off in RELEASE ignored
        vecs[7]  = mk(0, 0, 300, 100,   0, 0,   0, 33);
        vecs[8]  = mk(1, 0, 200, 200, 200, 1, 200, 11);
        vecs[9]  = mk(0, 0, 200, 200, 200, 2, 200, 22);  // peak reached: one-cycle ATTACK
        vecs[10] = mk(0, 0, 200, 200, 200, 3, 200, 22);  // sustain==peak: one-cycle DECAY
        vecs[11] = mk(0, 0, 999,   5, 200, 3, 200, 22);  // config change mid-note ignored
        vecs[12] = mk(0, 1, 999,   5, 200, 4,   0, 33);
        vecs[13] = mk(0, 0, 999,   5,   0, 0,   0, 33);
        for (int i = 0; i < 14; i++) begin
            drive_t(vecs[i].gon, vecs[i].goff, vecs[i].peak, vecs[i].sus,
                    16'd11, 16'd22, 16'd33, vecs[i].lerp);
            cyc();
            check_out($sformatf("vec%0d", i), bus_t.state, bus_t.target, bus_t.speed,
                      bus_t.busy, bus_t.timeout_flag, vecs[i].st, vecs[i].tgt, vecs[i].spd, 1'b0);
        end
        drive_t(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);

        // ---------------- timeout: lerp stuck at 0 ----------------
        drive_t(1'b1, 1'b0, 16'd777, 16'd555, 16'd1, 16'd2, 16'd3, 16'd0);
        cyc();
        bus_t.gate_on = 1'b0;
        check("to_attack_entry", 64'(bus_t.state), 64'd1);
        n = 0;
        while (bus_t.state == 3'd1 && n < 100) begin
            cyc();
            n++;
        end
        check("to_attack_cycles", 64'(n), 64'd16);
        check_out("to_decay", bus_t.state, bus_t.target, bus_t.speed, bus_t.busy,
                  bus_t.timeout_flag, 3'd2, 16'd555, 16'd2, 1'b1);
        n = 0;
        while (bus_t.state == 3'd2 && n < 100) begin
            cyc();
            n++;
        end
        check("to_decay_cycles", 64'(n), 64'd16);
        check_out("to_sustain", bus_t.state, bus_t.target, bus_t.speed, bus_t.busy,
                  bus_t.timeout_flag, 3'd3, 16'd555, 16'd2, 1'b1);
        bus_t.gate_on = 1'b1;
        cyc();
        bus_t.gate_on = 1'b0;
        check_out("to_clear", bus_t.state, bus_t.target, bus_t.speed, bus_t.busy,
                  bus_t.timeout_flag, 3'd1, 16'd777, 16'd1, 1'b0);

        // ---------------- randomized run vs reference model ----------------
        rst_t = 1'b1;
        @(negedge clk);
        rst_t = 1'b0;
        m_state = 0; m_age = 0; m_tgt = '0; m_spd = '0; m_sus = '0; m_ds = '0; m_rs = '0;
        m_flag = 1'b0;
        peak = 16'd2; sus = 16'd1; as = 16'd5; ds = 16'd6; rs = 16'd7;
        for (int i = 0; i < 3000; i++) begin
            gon  = ($urandom_range(0, 19) == 0);
            goff = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 3) == 0) begin
                peak = 16'($urandom_range(0, 3));
                sus  = 16'($urandom_range(0, 3));
                as   = 16'($urandom);
                ds   = 16'($urandom);
                rs   = 16'($urandom);
            end
            lerp = ($urandom_range(0, 9) == 0) ? m_tgt : 16'($urandom_range(0, 3));
            drive_t(gon, goff, peak, sus, as, ds, rs, lerp);
            model_step(gon, goff, peak, sus, as, ds, rs, lerp);
            cyc();
            check_out($sformatf("rand%0d", i), bus_t.state, bus_t.target, bus_t.speed,
                      bus_t.busy, bus_t.timeout_flag, 3'(m_state), m_tgt, m_spd, m_flag);
        end
        drive_t(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);

        // ---------------- full ADSR with behavioural lerper ----------------
        bus_a.peak_level = 16'd5000; bus_a.sustain_level = 16'd2000;
        bus_a.attack_speed = 16'd3; bus_a.decay_speed = 16'd3; bus_a.release_speed = 16'd3;
        bus_a.gate_on = 1'b1;
        cyc();
        bus_a.gate_on = 1'b0;
        prev = 3'd0;
        for (int i = 0; i < 3000; i++) begin
            if (bus_a.state != prev) begin
                seq_st.push_back(bus_a.state);
                seq_tgt.push_back(bus_a.target);
                prev = bus_a.state;
            end
            cyc();
        end
        bus_a.gate_off = 1'b1;
        cyc();
        bus_a.gate_off = 1'b0;
        n = 0;
        while (n < 5000) begin
            if (bus_a.state != prev) begin
                seq_st.push_back(bus_a.state);
                seq_tgt.push_back(bus_a.target);
                prev = bus_a.state;
            end
            if (bus_a.state == 3'd0) break;
            cyc();
            n++;
        end
        check("adsr_num_phases", 64'(seq_st.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            logic [2:0]  est[5];
            logic [15:0] etg[5];
            est = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
            etg = '{16'd5000, 16'd2000, 16'd2000, 16'd0, 16'd0};
            if (i < seq_st.size()) begin
                check($sformatf("adsr_state%0d", i), 64'(seq_st[i]), 64'(est[i]));
                check($sformatf("adsr_target%0d", i), 64'(seq_tgt[i]), 64'(etg[i]));
            end
        end
        check("adsr_idle_lerp", 64'(bus_a.lerp_value), 64'd0);
        check("adsr_idle_state", 64'(bus_a.state), 64'd0);
        check("adsr_timeout", 64'(bus_a.timeout_flag), 64'd0);

        // ---------------- retrigger during RELEASE at lerp=1200 ----------------
        bus_a.attack_speed = 16'd4; bus_a.decay_speed = 16'd4; bus_a.release_speed = 16'd4;
        bus_a.gate_on = 1'b1;
        cyc();
        bus_a.gate_on = 1'b0;
        n = 0;
        while (bus_a.state != 3'd3 && n < 5000) begin
            cyc();
            n++;
        end
        bus_a.gate_off = 1'b1;
        cyc();
        bus_a.gate_off = 1'b0;
        n = 0;
        while (!(bus_a.state == 3'd4 && bus_a.lerp_value == 16'd1200) && n < 1000) begin
            cyc();
            n++;
        end
        check("retrig_setup_lerp", 64'(bus_a.lerp_value), 64'd1200);
        bus_a.gate_on = 1'b1;
        cyc();
        bus_a.gate_on = 1'b0;
        check_out("retrig_attack", bus_a.state, bus_a.target, bus_a.speed, bus_a.busy,
                  bus_a.timeout_flag, 3'd1, 16'd5000, 16'd4, 1'b0);
        check("retrig_lerp0", 64'(bus_a.lerp_value), 64'd1196);
        cyc();
        cyc();
        check("retrig_lerp2", 64'(bus_a.lerp_value), 64'd1204);

        // ---------------- shadowing of sustain_level ----------------
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        bus_a.attack_speed = 16'd3; bus_a.decay_speed = 16'd3; bus_a.release_speed = 16'd3;
        bus_a.gate_on = 1'b1;
        cyc();
        bus_a.gate_on = 1'b0;
        bus_a.sustain_level = 16'd100;
        n = 0;
        while (bus_a.state != 3'd2 && n < 3000) begin
            cyc();
            n++;
        end
        check_out("shadow_decay", bus_a.state, bus_a.target, bus_a.speed, bus_a.busy,
                  bus_a.timeout_flag, 3'd2, 16'd2000, 16'd3, 1'b0);

        // ---------------- async reset mid-DECAY ----------------
        cyc();
        #2;
        rst_a = 1'b1;
        #1;
        check_out("async_reset", bus_a.state, bus_a.target, bus_a.speed, bus_a.busy,
                  bus_a.timeout_flag, 3'd0, 16'd0, 16'd0, 1'b0);
        @(negedge clk);
        rst_a = 1'b0;
        cyc();
        cyc();
        check("post_reset_idle", 64'(bus_a.state), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/envelope_sequencer.md
# envelope_sequencer

Per-voice ADSR controller for the audio system's lerper. The lerper owns the ramp arithmetic; this block sequences it by driving the lerper's 16-bit target and signed 16-bit speed through attack, decay, sustain and release phases. It watches the lerper's output to decide when each phase is complete, and falls back to a watchdog timeout if that output never arrives. One instance sits between the note/gate logic and each voice's lerper.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1048576: maximum number of cycles a ramp phase may last before the block forces the next transition.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous reset, active-high. The clock is single, the reset is asynchronous and active-high, and both are fixed.
- `gate_on`  in  1: one-cycle pulse that starts or retriggers a note.
- `gate_off`  in  1: one-cycle pulse that releases the note.
- `peak_level`  in  16: attack target, unsigned.
- `sustain_level`  in  16: decay target, unsigned.
- `attack_speed`, `decay_speed`, `release_speed`  in  16 each: signed speed codes, passed to the lerper unchanged.
- `lerp_value`  in  16: the lerper's `o_signal`, used as feedback.
- `target`  out  16: connects to the lerper's `i_signal`.
- `speed`  out  16: connects to the lerper's `speed`.
- `state`  out  3: encoded as IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `busy`  out  1: high whenever `state` is not IDLE.
- `timeout_flag`  out  1: sticky; set when any phase times out.

## Operation

- Configuration is shadowed:
  - All five config inputs are latched into shadow registers on an accepted `gate_on`.
  - Changing the config mid-note has no effect until the next `gate_on`.
- `reached` means `lerp_value == target_reg`. It is a combinational compare against the registered target.
- Phase timer:
  - Counts cycles in ATTACK, DECAY and RELEASE. It is held at 0 in IDLE and SUSTAIN.
  - It resets to 0 on every state change.
  - `expired` means the timer equals `TIMEOUT_CYCLES-1`.
- State transitions (priority order within each state):
  - Any state, on `gate_on`: go to ATTACK. Set target to the new `peak_level` and speed to the new `attack_speed`. Clear `timeout_flag`.
  - ATTACK, DECAY or SUSTAIN, on `gate_off`: go to RELEASE. Set target to 0 and speed to the shadow `release_speed`.
  - ATTACK, when `reached` or `expired`: go to DECAY. Set target to the shadow `sustain_level` and speed to the shadow `decay_speed`.
  - DECAY, when `reached` or `expired`: go to SUSTAIN. Target and speed are held.
  - RELEASE, when `reached` or `expired`: go to IDLE. Target stays 0; speed is held.
  - `expired` additionally sets `timeout_flag`.
- Ignored events:
  - `gate_off` in IDLE or RELEASE.
  - `gate_off` in the same cycle as `gate_on`, because `gate_on` wins.
- Retrigger:
  - `gate_on` during any phase restarts ATTACK from the current `lerp_value`.
  - The lerper output is never forced to 0.
- Degenerate levels:
  - If `sustain_level == peak_level`, DECAY lasts exactly one cycle.
  - If `peak_level == lerp_value` at trigger, ATTACK lasts one cycle.

## Timing

- Reset values: `state`=IDLE, `target`=0, `speed`=0, `busy`=0, `timeout_flag`=0, timer=0, shadows=0.
- All outputs are registered.
- Response latency:
  - A gate pulse sampled at edge N shows its effect on the outputs after edge N.
  - A `reached` condition seen in cycle N changes state at edge N+1.
  - There is no lookahead.
- `busy` is decoded from the state register and has no extra delay.
- Reset asserted mid-phase clears everything immediately and asynchronously. After release, the block waits in IDLE for the next `gate_on`.
- Gate pulses longer than one cycle are treated as repeated events:
  - A held `gate_on` keeps retriggering ATTACK every cycle.
  - Upstream guarantees single-cycle pulses.

## Structure

- A shared audio package holds:
  - the state enum (3-bit),
  - `AUDIO_W = 16`,
  - the default for `TIMEOUT_CYCLES`.
- The phase timer is one sub-module, `phase_timer`, with ports `clk`, `rst`, `clear`, `enable` and `expired`. Its width is `$clog2(TIMEOUT_CYCLES)`.
- Everything else is the FSM and output registers in a single module.

## Test plan

- Full ADSR cycle:
  - Stimulus: reset, then peak=5000, sustain=2000, speeds 3/3/3, with a behavioural lerper (±speed per cycle, clamped at target). Pulse `gate_on`; pulse `gate_off` 3000 cycles later.
  - Required: states go 1→2→3→4→0.
  - Required: `target` goes 5000→2000→0.
  - Required: IDLE is reached when `lerp_value`=0, and `timeout_flag`=0.
- Retrigger:
  - Stimulus: `gate_on` during RELEASE while `lerp_value`=1200.
  - Required: next cycle `state`=ATTACK, `target`=peak, and the ramp continues from 1200.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=16, `lerp_value` stuck at 0, `gate_on`.
  - Required: ATTACK→DECAY exactly 16 cycles after entry, and `timeout_flag`=1.
  - Required: `timeout_flag` clears on the next `gate_on`.
- Simultaneous gates:
  - Stimulus: `gate_on` and `gate_off` in the same cycle, from SUSTAIN.
  - Required: `state`=ATTACK.
  - Stimulus: `gate_off` alone in IDLE.
  - Required: no change.
- Shadowing:
  - Stimulus: change `sustain_level` 2000→100 during ATTACK.
  - Required: DECAY `target`=2000.
- Async reset:
  - Stimulus: assert `rst` mid-DECAY, between clock edges.
  - Required: outputs go to their reset values before the next edge.
